// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line filters:
// FSM states, error codes, common command bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StWaitIdle,
    StFail
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw open-drain PS/2 line: 2-FF synchronizer, FilterLen-sample
// glitch filter and a one-cycle falling-edge pulse aligned with the filtered level.
module ps2_line_filter #(
  parameter int unsigned FilterLen = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CntW = (FilterLen > 1) ? $clog2(FilterLen) : 1;

  logic            sync1_q, sync2_q;
  logic            filt_q, filt_d;
  logic            fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clr_i) begin
      // Restart from the current synchronized level without reporting an edge.
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      if (cnt_q == CntW'(FilterLen - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d & ~clr_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = filt_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request, shift 8 data bits plus
// parity and stop on device clock falls, then check ACK. PS2_TX_RETRY_EN enables retries.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RetryLimit = MAX_RETRY;
`else
  localparam int unsigned RetryLimit = 0;
`endif
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

  ps2_state_e        state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic              par_q, par_d;
  logic [3:0]        bit_n_q, bit_n_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              clk_oe_q, clk_oe_d;
  logic              data_oe_q, data_oe_d;

  logic       clk_level, clk_fall, data_level, data_fall, filt_clr;
  logic       timeout, fail;
  logic [1:0] fail_code;

  assign filt_clr = (state_q == StIdle);
  assign timeout  = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  ps2_line_filter #(
    .FilterLen(FILTER_LEN)
  ) u_clk_filter (
    .clk_i  (clk),
    .rst_ni (rstn),
    .clr_i  (filt_clr),
    .line_i (ps2_clk_i),
    .level_o(clk_level),
    .fall_o (clk_fall)
  );

  ps2_line_filter #(
    .FilterLen(FILTER_LEN)
  ) u_data_filter (
    .clk_i  (clk),
    .rst_ni (rstn),
    .clr_i  (filt_clr),
    .line_i (ps2_data_i),
    .level_o(data_level),
    .fall_o (data_fall)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    par_d      = par_q;
    bit_n_d    = bit_n_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    clk_oe_d   = 1'b0;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    fail       = 1'b0;
    fail_code  = ERR_NONE;

    unique case (state_q)
      StIdle: begin
        data_oe_d = 1'b0;
        cnt_d     = '0;
        bit_n_d   = '0;
        if (tx_valid) begin
          data_d     = tx_data;
          par_d      = odd_parity(tx_data);
          retry_d    = '0;
          err_code_d = ERR_NONE;
          clk_oe_d   = 1'b1;
          state_d    = StInhibit;
        end
      end
      StInhibit: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
          // Clock stays pulled for the first REQ cycle while data drops for the start bit.
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = StReq;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReq: begin
        data_oe_d = 1'b1;
        if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_fall) begin
            data_oe_d = ~data_q[0];
            bit_n_d   = 4'd2;
            state_d   = StShift;
          end
        end
      end
      StShift: begin
        if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_fall) begin
            bit_n_d = bit_n_q + 1'b1;
            if (bit_n_q <= 4'd8) begin
              data_oe_d = ~data_q[3'(bit_n_q - 4'd1)];
            end else if (bit_n_q == 4'd9) begin
              data_oe_d = ~par_q;
            end else if (bit_n_q == 4'd10) begin
              data_oe_d = 1'b0;
            end else begin
              data_oe_d = 1'b0;
              if (data_level) begin
                fail      = 1'b1;
                fail_code = ERR_NACK;
              end else begin
                state_d = StWaitIdle;
              end
            end
          end
        end
      end
      StWaitIdle: begin
        data_oe_d = 1'b0;
        if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_level && data_level && !data_fall) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StFail: begin
        data_oe_d = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = StIdle;
      end
    endcase

    if (fail) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      cnt_d     = '0;
      if (retry_q != RetryW'(RetryLimit)) begin
        retry_d  = retry_q + 1'b1;
        clk_oe_d = 1'b1;
        state_d  = StInhibit;
      end else begin
        err_d      = 1'b1;
        err_code_d = fail_code;
        state_d    = StFail;
      end
    end

    tx_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      data_q     <= '0;
      par_q      <= 1'b0;
      bit_n_q    <= '0;
      cnt_q      <= '0;
      retry_q    <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_q      <= par_d;
      bit_n_q    <= bit_n_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on the open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned InhibitCycles = 20;
  localparam int unsigned TimeoutCycles = 3000;
  localparam int unsigned FilterLen     = 2;
  localparam int unsigned MaxRetry      = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, err;
  logic [1:0] err_code;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  always #5 clk = ~clk;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhibitCycles),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .FILTER_LEN    (FilterLen),
    .MAX_RETRY     (MaxRetry)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Line monitor: pulse counts, inhibit phases, REQ entry and error timing.
  int unsigned cyc = 0, done_total = 0, err_total = 0;
  int unsigned inh_cycles = 0, inh_phases = 0, req_cyc = 0, err_cyc = 0;
  logic [1:0]  err_oe = 2'b00;
  logic        prev_inh = 1'b0, prev_req = 1'b0;
  logic        mon_inh, mon_req;
  assign mon_inh = ps2_clk_oe & ~ps2_data_oe;
  assign mon_req = ps2_clk_oe & ps2_data_oe;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_total <= done_total + 1;
    if (err === 1'b1) begin
      err_total <= err_total + 1;
      err_cyc   <= cyc;
      err_oe    <= {ps2_clk_oe, ps2_data_oe};
    end
    if (mon_inh === 1'b1) inh_cycles <= inh_cycles + 1;
    if (mon_inh === 1'b1 && !prev_inh) inh_phases <= inh_phases + 1;
    if (mon_req === 1'b1 && !prev_req) req_cyc <= cyc;
    prev_inh <= (mon_inh === 1'b1);
    prev_req <= (mon_req === 1'b1);
  end

  // Reference frame as the device should see it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i + 1] = ((int'(b) >> i) % 2) == 1;
      ones += (int'(b) >> i) % 2;
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    n_checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL accept: tx_ready=%b busy=%b, required 0 1", tx_ready, busy);
    end
  endtask

  // Device side: wait for the request, then clock `falls` falling edges at 200-cycle period.
  task automatic device_frame(input bit ack, input int gap, input int falls,
                              output logic [10:0] seen, output bit ok);
    int n = 0;
    seen = '1;
    ok   = 1'b0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_i === 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n < 1000) begin
      ok      = 1'b1;
      seen[0] = ps2_data_i;
      repeat (gap) @(negedge clk);
      for (int k = 1; k <= falls; k++) begin
        dev_clk_low = 1'b1;
        repeat (100) @(negedge clk);
        if (k <= 10) seen[k] = ps2_data_i;
        dev_clk_low = 1'b0;
        if (k == 10) begin
          repeat (50) @(negedge clk);
          dev_data_low = ack;
          repeat (50) @(negedge clk);
        end else begin
          repeat (100) @(negedge clk);
        end
      end
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    tx_valid = 1'b1;
    tx_data  = PS2_CMD_RESET;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_ready, busy, done, err, err_code, ps2_clk_oe, ps2_data_oe} !== 8'b1000_0000) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b, required 10000000",
               {tx_ready, busy, done, err, err_code, ps2_clk_oe, ps2_data_oe});
    end
    tx_valid = 1'b0;
    rstn     = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_no_latch: busy=%b tx_ready=%b clk_oe=%b, required 0 1 0",
               busy, tx_ready, ps2_clk_oe);
    end
  endtask

  task automatic test_frame(input logic [7:0] b, input bit ack, input int gap);
    logic [10:0] seen, expv;
    bit          ok;
    int unsigned d0 = done_total, e0 = err_total, i0 = inh_cycles, p0 = inh_phases;
    expv = frame_bits(b);
    send_byte(b);
    device_frame(ack, gap, 11, seen, ok);
    wait_idle();
    n_checks++;
    if (!ok || seen !== expv) begin
      n_errors++;
      $display("FAIL frame_bits %h: saw %b (req %0d), required %b", b, seen, ok, expv);
    end
    n_checks++;
    if (inh_cycles - i0 != InhibitCycles || inh_phases - p0 != 1) begin
      n_errors++;
      $display("FAIL inhibit %h: %0d cycles %0d phases, required %0d 1", b,
               inh_cycles - i0, inh_phases - p0, InhibitCycles);
    end
    n_checks++;
    if (done_total - d0 != (ack ? 1 : 0) || err_total - e0 != (ack ? 0 : 1)) begin
      n_errors++;
      $display("FAIL outcome %h: done=%0d err=%0d, required ack=%0d", b,
               done_total - d0, err_total - e0, ack);
    end
    n_checks++;
    if (err_code !== (ack ? ERR_NONE : ERR_NACK)) begin
      n_errors++;
      $display("FAIL err_code %h: got %b, required %b", b, err_code, ack ? ERR_NONE : ERR_NACK);
    end
    n_checks++;
    if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0
        || (!ack && err_oe !== 2'b00)) begin
      n_errors++;
      $display("FAIL release %h: tx_ready=%b oe=%b%b err_oe=%b, required 1 00 00", b,
               tx_ready, ps2_clk_oe, ps2_data_oe, err_oe);
    end
  endtask

  task automatic test_timeout();
    int unsigned d0 = done_total, e0 = err_total;
    int n = 0;
    send_byte(PS2_CMD_RESET);
    while (err_total == e0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (err_total != e0 + 1) begin
      n_errors++;
      $display("FAIL timeout_err: %0d err pulses, required 1", err_total - e0);
    end
    n_checks++;
    if (err_cyc - req_cyc != TimeoutCycles) begin
      n_errors++;
      $display("FAIL timeout_latency: %0d cycles, required %0d", err_cyc - req_cyc,
               TimeoutCycles);
    end
    n_checks++;
    if (err_code !== ERR_TIMEOUT || err_oe !== 2'b00 || done_total != d0) begin
      n_errors++;
      $display("FAIL timeout_state: code=%b oe=%b done=%0d, required 01 00 0", err_code,
               err_oe, done_total - d0);
    end
    wait_idle();
  endtask

  task automatic test_reset_midshift();
    logic [10:0] seen;
    bit          ok;
    int unsigned d0, e0;
    send_byte(PS2_CMD_SET_LED);
    device_frame(1'b1, 50, 5, seen, ok);
    d0   = done_total;
    e0   = err_total;
    rstn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midshift_reset: oe=%b%b tx_ready=%b busy=%b, required 00 1 0",
               ps2_clk_oe, ps2_data_oe, tx_ready, busy);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (!ok || done_total != d0 || err_total != e0) begin
      n_errors++;
      $display("FAIL midshift_pulses: req=%0d done=%0d err=%0d, required 1 0 0", ok,
               done_total - d0, err_total - e0);
    end
    test_frame(PS2_CMD_SET_LED, 1'b1, 60);
  endtask

  task automatic test_retry();
    logic [10:0] s1, s2, s3;
    bit          ok1, ok2, ok3;
    int unsigned d0 = done_total, e0 = err_total, p0 = inh_phases;
    send_byte(PS2_CMD_SET_LED);
    device_frame(1'b0, 50, 11, s1, ok1);
    device_frame(1'b0, 50, 11, s2, ok2);
    device_frame(1'b1, 50, 11, s3, ok3);
    wait_idle();
    n_checks++;
    if (!(ok1 && ok2 && ok3) || s3 !== frame_bits(PS2_CMD_SET_LED)) begin
      n_errors++;
      $display("FAIL retry_frame: req=%0d%0d%0d bits=%b, required 111 %b", ok1, ok2, ok3, s3,
               frame_bits(PS2_CMD_SET_LED));
    end
    n_checks++;
    if (inh_phases - p0 != 3) begin
      n_errors++;
      $display("FAIL retry_inhibits: %0d, required 3", inh_phases - p0);
    end
    n_checks++;
    if (done_total - d0 != 1 || err_total != e0 || err_code !== ERR_NONE) begin
      n_errors++;
      $display("FAIL retry_outcome: done=%0d err=%0d code=%b, required 1 0 00",
               done_total - d0, err_total - e0, err_code);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b   = 8'($urandom);
      int         gap = int'($urandom_range(10, 80));
`ifdef PS2_TX_RETRY_EN
      bit         ack = 1'b1;
`else
      bit         ack = 1'($urandom_range(0, 1));
`endif
      test_frame(b, ack, gap);
    end
  endtask

  initial begin
    test_reset();
    test_frame(PS2_CMD_SET_LED, 1'b1, 50);
    test_frame(PS2_CMD_ENABLE, 1'b1, 30);
`ifdef PS2_TX_RETRY_EN
    test_retry();
`else
    test_frame(PS2_CMD_ENABLE, 1'b0, 40);
    test_timeout();
`endif
    test_reset_midshift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
